uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: the successor to the fixed 8N1 receiver in the task-6 UART path. It adds configurable data width, parity and stop bits, 16x oversampling with majority vote, error flags and a held-valid/ack handshake. An optional receive FIFO can be compiled in. It sits between the `rx` pin and `ctrl_uart`-style consumers.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `BAUD`, 9600: line rate.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 8: power of 2, ≥2; used only with `UART_RX_FIFO_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous reset, active-high.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out DATA_BITS: received word, LSB received first.
- `rx_valid` out 1: `rx_data` and error flags valid; held until acked.
- `rx_ack` in 1: consumer accepts the current word; ignored when `rx_valid`=0.
- `parity_err` out 1: parity mismatch for the current word.
- `frame_err` out 1: a stop bit sampled 0 for the current word.
- `overrun` out 1: sticky; a frame was dropped.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`.
- Tick divider: DIV = CLK_FREQ/(BAUD*16), integer truncation (325 at defaults). Tick counter runs only outside IDLE and restarts on the start edge.
- Each bit is 16 ticks. The bit value is the majority of `rx_s` at ticks 7, 8 and 9.
- FSM states are ARM, IDLE, START, DATA, PARITY, STOP, DONE.
  - ARM: entered at reset. Moves to IDLE after 16 consecutive ticks with `rx_s`=1; any 0 restarts the count.
  - IDLE: on a 1→0 transition of `rx_s`, go to START.
  - START: if the majority is 1, this is a false start; return to IDLE and emit nothing. Otherwise go to DATA.
  - DATA: shift DATA_BITS bits, LSB first.
  - PARITY: skipped when PARITY=0. Sets `parity_err` when the XOR of data bits and the parity bit ≠ (PARITY==1).
  - STOP: repeated STOP_BITS times. Any stop bit with majority 0 sets `frame_err`. A break (all data 0, stop 0) reports as `frame_err`.
  - DONE: delivers the word, then goes to IDLE. After a framing error it goes to ARM instead.
- Delivery with the FIFO compiled out:
  - If `rx_valid`=0, or `rx_ack`=1 in the same cycle, load data and flags and set `rx_valid`.
  - Otherwise drop the new word, set `overrun`, and keep the old word unchanged.
- `rx_ack` with `rx_valid`=1 clears `rx_valid` and `overrun` on the next edge. When ack and delivery coincide, the new word wins and `rx_valid` stays 1.
- Error flags change only when a word is loaded.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0. FSM resets to ARM.
- Reset asserted mid-frame aborts the frame immediately; no partial word is ever output.
- Start detect latency: 2 clk (synchronizer) + 1 clk (edge register).
- `rx_valid` rises 1 clk after the tick-9 sample of the last stop bit. That is ≈(1+DATA_BITS+P+STOP_BITS−0.44) bit times after the start edge, where P is 1 when parity is enabled, else 0.
- `busy` rises 1 clk after the start edge and falls in the cycle DONE exits.
- `rx_ack` is sampled every rising edge. One ack consumes exactly one word.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - A FIFO_DEPTH × (DATA_BITS+2) first-word-fall-through FIFO stores {parity_err, frame_err, data}.
  - `rx_valid` = not empty. Outputs show the head entry; `rx_ack` pops.
  - A push while full is dropped and sets `overrun`. Pop and push in the same cycle when full both succeed with no overrun.
  - `overrun` clears on the next `rx_ack`.
  - Pointers wrap modulo FIFO_DEPTH. A count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- `UART_RX_FIFO_EN` undefined: single holding register, behaving exactly as described in Operation.

## Test plan
- Defaults, 20 ns clk, 104160 ns bit: send 0x73, then ack 1 clk after `rx_valid` → `rx_data`=0x73, both error flags 0, `rx_valid` falls the next clk.
- PARITY=2: send 0x03 with parity bit 1 → `parity_err`=1 with `rx_data`=0x03. Send 0x74 with parity bit 0 → `parity_err`=0.
- Stop bit driven 0 on 0x74 → `frame_err`=1. The receiver re-arms only after 1 bit time of idle; a 0x03 sent afterwards is received clean.
- 3 µs low glitch on idle `rx` → no `rx_valid`; `busy` pulses, then returns to 0.
- No FIFO: send 0x73 then 0x03 with no ack → `rx_data` stays 0x73 and `overrun`=1. A single ack clears both `rx_valid` and `overrun`.
- `UART_RX_FIFO_EN`, FIFO_DEPTH=2: send 0x73, 0x03, 0x74 with no ack → `overrun`=1; acks pop 0x73 then 0x03, then `rx_valid`=0. Separately, asserting `rst` mid-frame → all outputs 0 and no word is delivered.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 16x oversampling with 3-sample vote.
// Define UART_RX_FIFO_EN to replace the holding register with a receive FIFO.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_ARM, S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE
    } state_t;

    state_t state, state_next;

    logic                 rx_m, rx_s, rx_d;
    logic                 start_edge;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [3:0]           tick_cnt, bit_cnt, arm_cnt;
    logic                 s7, s8, maj;
    logic                 sample9, bit_end;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_acc, ferr_acc;
    logic                 w_perr;
    logic                 deliver;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_m, rx_s, rx_d} <= 3'b111;
        end else begin
            {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
        end
    end

    assign start_edge = rx_d & ~rx_s;

    // Divider is held in IDLE so every frame starts phase-aligned to its edge
    assign tick = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign sample9 = tick && (tick_cnt == 4'd8);
    assign bit_end = tick && (tick_cnt == 4'd15);
    assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_ARM: begin
                if (tick && rx_s && arm_cnt == 4'd15) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (start_edge) state_next = S_START;
            end
            S_START: begin
                if (sample9 && maj) state_next = S_IDLE;
                else if (bit_end)   state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
                    state_next = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (sample9 && bit_cnt == 4'(STOP_BITS - 1))
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = ferr_acc ? S_ARM : S_IDLE;
            end
            default: state_next = S_ARM;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        deliver = 1'b0;
        unique case (state)
            S_ARM, S_IDLE: busy = 1'b0;
            S_DONE:        deliver = 1'b1;
            default:       busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            arm_cnt  <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            data_sr  <= '0;
            par_acc  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (state == S_IDLE) tick_cnt <= '0;
            else if (tick)       tick_cnt <= tick_cnt + 4'd1;

            if (state_next != state) bit_cnt <= '0;
            else if (bit_end)        bit_cnt <= bit_cnt + 4'd1;

            if (state != S_ARM || !rx_s) arm_cnt <= '0;
            else if (tick)               arm_cnt <= arm_cnt + 4'd1;

            if (tick && tick_cnt == 4'd6) s7 <= rx_s;
            if (tick && tick_cnt == 4'd7) s8 <= rx_s;

            if (sample9) begin
                if (state == S_START) begin
                    par_acc  <= 1'b0;
                    ferr_acc <= 1'b0;
                end
                if (state == S_DATA) begin
                    data_sr <= {maj, data_sr[DATA_BITS-1:1]};
                    par_acc <= par_acc ^ maj;
                end
                if (state == S_PAR)          par_acc  <= par_acc ^ maj;
                if (state == S_STOP && !maj) ferr_acc <= 1'b1;
            end
        end
    end

    assign w_perr = (PARITY != 0) && (par_acc != (PARITY == 1));

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS+1:0] head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 pop, full, push_ok;

    assign rx_valid = (count != '0);
    assign pop      = rx_valid && rx_ack;
    assign full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign push_ok  = deliver && (!full || pop);
    assign head     = mem[rd_ptr];

    assign {parity_err, frame_err, rx_data} = rx_valid ? head : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {w_perr, ferr_acc, data_sr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (deliver && full && !pop) overrun <= 1'b1;
            else if (pop)                overrun <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            // A word landing on the ack cycle replaces the one being consumed
            if (deliver) begin
                if (!rx_valid || rx_ack) begin
                    rx_data    <= data_sr;
                    parity_err <= w_perr;
                    frame_err  <= ferr_acc;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param, 8N1 and 8E1 instances.
// Baud is raised so one bit is 64 clk (DIV=4) and every frame stays short.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 781_250;
    localparam int BIT_CLK  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       ack0 = 1'b0, ack1 = 1'b0;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1;
    logic       ferr0, ferr1, ovr0, ovr1, busy0, busy1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] d;
        bit         pb;
        bit         sb;
        logic [7:0] q;
        bit         pe;
        bit         fe;
    } vec_t;

    vec_t vt [7];

    always #10 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)
    ) u_plain (
        .clk(clk), .rst(rst), .rx(rx0),
        .rx_data(data0), .rx_valid(valid0), .rx_ack(ack0),
        .parity_err(perr0), .frame_err(ferr0),
        .overrun(ovr0), .busy(busy0)
    );

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)
    ) u_even (
        .clk(clk), .rst(rst), .rx(rx1),
        .rx_data(data1), .rx_valid(valid1), .rx_ack(ack1),
        .parity_err(perr1), .frame_err(ferr1),
        .overrun(ovr1), .busy(busy1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int ln, input logic v);
        if (ln == 0) rx0 = v;
        else         rx1 = v;
    endtask

    task automatic bits(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send(input int ln, input logic [7:0] d,
                        input bit pen, input bit pb, input bit sb);
        drive(ln, 1'b0);
        bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(ln, d[i]);
            bits(1);
        end
        if (pen) begin
            drive(ln, pb);
            bits(1);
        end
        drive(ln, sb);
        bits(1);
        drive(ln, 1'b1);
    endtask

    function automatic logic vld(input int ln);
        return (ln == 0) ? valid0 : valid1;
    endfunction

    task automatic wait_valid(input int ln, input string name);
        int n = 0;
        while (!vld(ln) && n < 2 * BIT_CLK) begin
            @(negedge clk);
            n++;
        end
        chk(name, vld(ln), 1);
    endtask

    task automatic ack(input int ln);
        if (ln == 0) ack0 = 1'b1;
        else         ack1 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        ack1 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bs, vs;
        // even parity: 0x03 and 0xFF need pb=0, 0x74 and 0xA5 need pb=0
        vt[0] = '{8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vt[1] = '{8'h74, 1'b0, 1'b1, 8'h74, 1'b0, 1'b0};
        vt[2] = '{8'h74, 1'b0, 1'b0, 8'h74, 1'b0, 1'b1};
        vt[3] = '{8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vt[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[5] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst valid0", valid0, 0);
        chk("rst data0", data0, 0);
        chk("rst perr0", perr0, 0);
        chk("rst ferr0", ferr0, 0);
        chk("rst ovr0", ovr0, 0);
        chk("rst busy0", busy0, 0);
        chk("rst valid1", valid1, 0);
        chk("rst busy1", busy1, 0);
        bits(2);

        send(0, 8'h73, 1'b0, 1'b0, 1'b1);
        wait_valid(0, "73 valid");
        chk("73 data", data0, 8'h73);
        chk("73 perr", perr0, 0);
        chk("73 ferr", ferr0, 0);
        ack(0);
        chk("73 valid after ack", valid0, 0);

        bits(1);
        drive(0, 1'b0);
        repeat (5) @(negedge clk);
        drive(0, 1'b1);
        bs = 1'b0;
        vs = 1'b0;
        repeat (2 * BIT_CLK) begin
            @(negedge clk);
            bs |= busy0;
            vs |= valid0;
        end
        chk("glitch busy pulse", bs, 1);
        chk("glitch no valid", vs, 0);
        chk("glitch busy idle", busy0, 0);

        bits(1);
        send(0, 8'h73, 1'b0, 1'b0, 1'b1);
        bits(1);
        send(0, 8'h03, 1'b0, 1'b0, 1'b1);
        bits(1);
`ifdef UART_RX_FIFO_EN
        send(0, 8'h74, 1'b0, 1'b0, 1'b1);
        bits(1);
        chk("ovr set", ovr0, 1);
        chk("ovr valid", valid0, 1);
        chk("ovr head 73", data0, 8'h73);
        ack(0);
        chk("ovr head 03", data0, 8'h03);
        chk("ovr cleared", ovr0, 0);
        chk("ovr valid 2nd", valid0, 1);
        ack(0);
        chk("ovr drained", valid0, 0);
`else
        chk("ovr valid", valid0, 1);
        chk("ovr kept 73", data0, 8'h73);
        chk("ovr set", ovr0, 1);
        ack(0);
        chk("ovr valid cleared", valid0, 0);
        chk("ovr cleared", ovr0, 0);
`endif

        foreach (vt[i]) begin
            bits(2);
            send(1, vt[i].d, 1'b1, vt[i].pb, vt[i].sb);
            wait_valid(1, $sformatf("row%0d valid", i));
            chk($sformatf("row%0d data", i), data1, vt[i].q);
            chk($sformatf("row%0d perr", i), perr1, vt[i].pe);
            chk($sformatf("row%0d ferr", i), ferr1, vt[i].fe);
            ack(1);
            chk($sformatf("row%0d valid after ack", i), valid1, 0);
        end

        bits(2);
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_valid(0, "a5 valid");
        chk("a5 data", data0, 8'hA5);
        bits(1);
        drive(0, 1'b0);
        bits(1);
        drive(0, 1'b1);
        bits(2);
        chk("midframe busy", busy0, 1);
        rst = 1'b1;
        #1;
        chk("midrst valid", valid0, 0);
        chk("midrst data", data0, 0);
        chk("midrst busy", busy0, 0);
        chk("midrst ovr", ovr0, 0);
        chk("midrst ferr", ferr0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        vs = 1'b0;
        repeat (10 * BIT_CLK) begin
            @(negedge clk);
            vs |= valid0;
        end
        chk("midrst no word", vs, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
